// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot T-ring clocked on the falling
// edge, plus a Moore decode of (T-state, latched opcode) into the control word.
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       CLK,
  input  logic       CLR_bar,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm_bar,
  output logic       CE_bar,
  output logic       Li_bar,
  output logic       Ei_bar,
  output logic       La_bar,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb_bar,
  output logic       Lo_bar,
  output logic       halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e   state_reg, state_next;
  logic       halted_reg, halted_next;
  logic [3:0] op_reg, op_next;
  logic       is_alu;
  logic       is_sub;

  // Ring, halt flag and opcode all move on the falling edge so the control
  // word is stable well before the rising edge where the datapath loads.
  always_ff @(negedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      state_reg  <= T1;
      halted_reg <= 1'b0;
      op_reg     <= 4'b0000;
    end else begin
      state_reg  <= state_next;
      halted_reg <= halted_next;
      op_reg     <= op_next;
    end
  end

  always_comb begin
    state_next  = T1;
    halted_next = halted_reg;
    op_next     = op_reg;
    if (halted_reg) begin
      state_next = T4;
    end else begin
      case (state_reg)
        T1: state_next = T2;
        T2: state_next = T3;
        // The opcode is captured once, when leaving T3; fetch-phase IR
        // activity never reaches the decode below.
        T3: begin
          op_next    = opcode;
          state_next = T4;
          if (opcode == OP_HLT) halted_next = 1'b1;
        end
        T4: state_next = T5;
        T5: state_next = T6;
        T6: state_next = T1;
        default: state_next = T1;
      endcase
    end
  end

  assign is_alu  = (op_reg == OP_ADD) || (op_reg == OP_SUB);
  assign is_sub  = (op_reg == OP_SUB);
  assign t_state = state_reg;
  assign halted  = halted_reg;

  // Decode depends only on falling-edge registers, so nothing moves at posedge.
  always_comb begin
    Cp     = 1'b0;
    Ep     = 1'b0;
    Lm_bar = 1'b1;
    CE_bar = 1'b1;
    Li_bar = 1'b1;
    Ei_bar = 1'b1;
    La_bar = 1'b1;
    Ea     = 1'b0;
    Su     = 1'b0;
    Eu     = 1'b0;
    Lb_bar = 1'b1;
    Lo_bar = 1'b1;
    if (CLR_bar && !halted_reg) begin
      case (state_reg)
        T1: begin
          Ep     = 1'b1;
          Lm_bar = 1'b0;
        end
        T2: Cp = 1'b1;
        T3: begin
          CE_bar = 1'b0;
          Li_bar = 1'b0;
        end
        T4: begin
          Su = is_sub;
          if ((op_reg == OP_LDA) || is_alu) begin
            Ei_bar = 1'b0;
            Lm_bar = 1'b0;
          end else if (op_reg == OP_OUT) begin
            Ea     = 1'b1;
            Lo_bar = 1'b0;
          end
        end
        T5: begin
          Su = is_sub;
          if (op_reg == OP_LDA) begin
            CE_bar = 1'b0;
            La_bar = 1'b0;
          end else if (is_alu) begin
            CE_bar = 1'b0;
            Lb_bar = 1'b0;
          end
        end
        T6: begin
          Su = is_sub;
          if (is_alu) begin
            Eu     = 1'b1;
            La_bar = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Scoreboard bench: the stimulus process pushes expected per-T-state snapshots,
// and a posedge monitor pops and compares them against the sequencer outputs.
module tb_sap1_controller_sequencer;

  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

  // Control word packing: {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}
  localparam logic [11:0] M_CP = 12'h800, M_EP = 12'h400, M_LM = 12'h200;
  localparam logic [11:0] M_CE = 12'h100, M_LI = 12'h080, M_EI = 12'h040;
  localparam logic [11:0] M_LA = 12'h020, M_EA = 12'h010, M_SU = 12'h008;
  localparam logic [11:0] M_EU = 12'h004, M_LB = 12'h002, M_LO = 12'h001;
  localparam logic [11:0] INACTIVE = 12'h3E3;

  logic       CLK, CLR_bar;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar, halted;

  int n_vec = 0;
  int n_err = 0;
  logic [18:0] sb[$];

  sap1_controller_sequencer dut (
    .CLK(CLK), .CLR_bar(CLR_bar), .opcode(opcode), .t_state(t_state),
    .Cp(Cp), .Ep(Ep), .Lm_bar(Lm_bar), .CE_bar(CE_bar), .Li_bar(Li_bar),
    .Ei_bar(Ei_bar), .La_bar(La_bar), .Ea(Ea), .Su(Su), .Eu(Eu),
    .Lb_bar(Lb_bar), .Lo_bar(Lo_bar), .halted(halted)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [11:0] ctrl_word();
    return {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar};
  endfunction

  // Reference: which controls an instruction asserts in each T-state.
  function automatic logic [11:0] active_set(int t, logic [3:0] op);
    logic       alu = (op == ADD) || (op == SUB);
    logic [11:0] su = (op == SUB) ? M_SU : 12'h000;
    case (t)
      1: return M_EP | M_LM;
      2: return M_CP;
      3: return M_CE | M_LI;
      4: if (op == LDA || alu) return M_EI | M_LM | su;
         else if (op == OUT) return M_EA | M_LO;
      5: if (op == LDA) return M_CE | M_LA;
         else if (alu) return M_CE | M_LB | su;
      6: if (alu) return M_EU | M_LA | su;
      default: return 12'h000;
    endcase
    return 12'h000;
  endfunction

  function automatic logic [18:0] expect_entry(int t, logic [3:0] op, logic h);
    logic [5:0] ring = 6'b000001 << (t - 1);
    logic [11:0] c = h ? INACTIVE : (INACTIVE ^ active_set(t, op));
    return {ring, h, c};
  endfunction

  task automatic check(string name, logic [18:0] got, logic [18:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got t=%b h=%b ctrl=%b, want t=%b h=%b ctrl=%b", name,
               got[18:13], got[12], got[11:0], want[18:13], want[12], want[11:0]);
    end
  endtask

  // Monitor: integrity every posedge, scoreboard pop when an entry is pending.
  initial begin
    logic [18:0] want;
    logic        ok;
    forever begin
      @(posedge CLK);
      #1;
      if (CLR_bar === 1'b1) begin
        n_vec++;
        ok = ($countones({Ep, ~CE_bar, ~Ei_bar, Ea, Eu}) <= 1) && $onehot(t_state);
        if (!ok) begin
          n_err++;
          $display("FAIL bus/onehot: t=%b drivers=%b, want one-hot ring and <=1 driver",
                   t_state, {Ep, ~CE_bar, ~Ei_bar, Ea, Eu});
        end
        if (sb.size() > 0) begin
          want = sb.pop_front();
          check("step", {t_state, halted, ctrl_word()}, want);
        end
      end
    end
  end

  // Called in T1 before its rising edge; stop_t < 6 leaves the DUT in that state.
  task automatic run_instr(logic [3:0] op, int stop_t);
    int last = (op == HLT) ? 3 : stop_t;
    for (int t = 1; t <= last; t++) sb.push_back(expect_entry(t, op, 1'b0));
    if (op == HLT)
      for (int k = 0; k < 21; k++) sb.push_back(expect_entry(4, op, 1'b1));
    for (int t = 1; t <= last; t++) begin
      opcode = (t >= 3) ? op : 4'($urandom);
      if (t < last) begin
        @(negedge CLK);
        #1;
      end
    end
    if (op == HLT) begin
      @(negedge CLK);
      #1;
      repeat (21) begin
        opcode = 4'($urandom);
        @(negedge CLK);
        #1;
      end
    end else if (stop_t == 6) begin
      @(negedge CLK);
      #1;
    end
  endtask

  // 7 ns reset pulse starting just after a rising edge; released 1 ns before the next.
  task automatic reset_pulse();
    @(posedge CLK);
    #2;
    CLR_bar = 1'b0;
    #1;
    check("reset_mid", {t_state, halted, ctrl_word()}, {6'b000001, 1'b0, INACTIVE});
    #6;
    CLR_bar = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    int guard;
    CLR_bar = 1'b0;
    opcode  = 4'b0000;
    @(negedge CLK);
    #1;
    check("reset_init", {t_state, halted, ctrl_word()}, {6'b000001, 1'b0, INACTIVE});
    #1;
    CLR_bar = 1'b1;

    run_instr(LDA, 6);
    run_instr(ADD, 6);
    run_instr(SUB, 6);
    run_instr(OUT, 6);
    run_instr(4'b0101, 6);
    run_instr(ADD, 5);
    reset_pulse();
    for (int i = 0; i < 50; i++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, 6);
    end
    run_instr(LDA, 6);
    run_instr(ADD, 6);
    run_instr(OUT, 6);
    run_instr(HLT, 6);
    reset_pulse();
    run_instr(SUB, 6);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge CLK);
      #2;
      guard++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sap1_controller_sequencer.md
Name: sap1_controller_sequencer

Overview:
Controller-sequencer for the SAP-1 datapath. It holds the six-state T-ring counter, decodes the instruction-register opcode nibble, and drives every control line, including Lm_bar to the MAR, the PC, RAM, IR, A, B, ALU and the output register. It is a Moore machine: the control word is a function of T-state and opcode only. The ring advances on the falling CLK edge, so the control word settles before the rising edge on which the datapath registers load.

Parameters:
OP_LDA, 4'b0000, load A from RAM[operand]
OP_ADD, 4'b0001, A <= A + RAM[operand]
OP_SUB, 4'b0010, A <= A - RAM[operand]
OP_OUT, 4'b1110, output register <= A
OP_HLT, 4'b1111, stop sequencing

Ports:
CLK  in  1  system clock; ring counter updates on negedge
CLR_bar  in  1  asynchronous, active-low reset
opcode  in  4  IR high nibble; valid from the rising edge inside T3 onward
t_state  out  6  one-hot ring state, bit0=T1 .. bit5=T6
Cp  out  1  PC increment enable, active-high
Ep  out  1  PC drives W bus, active-high
Lm_bar  out  1  MAR load, active-low
CE_bar  out  1  RAM drives W bus, active-low
Li_bar  out  1  IR load, active-low
Ei_bar  out  1  IR low nibble drives W bus, active-low
La_bar  out  1  A load, active-low
Ea  out  1  A drives W bus, active-high
Su  out  1  ALU subtract select, 1=subtract
Eu  out  1  ALU drives W bus, active-high
Lb_bar  out  1  B load, active-low
Lo_bar  out  1  output register load, active-low
halted  out  1  HLT reached; the block stays frozen until reset

Behaviour:
- Reset (CLR_bar=0, asynchronous, any time, including mid-instruction):
  - t_state=6'b000001 and halted=0.
  - All controls are forced inactive: Cp=Ep=Ea=Su=Eu=0; every *_bar output = 1.
  - These forced values hold for as long as CLR_bar=0. On release, T1 decode takes effect immediately, and the first advance is on the next negedge.
- Ring sequence: T1->T2->...->T6->T1, one step per negedge CLK. Exactly one t_state bit is high at all times.
- Inactive level: any control not listed below is inactive.
- Fetch, identical for all opcodes:
  - T1: Ep=1, Lm_bar=0
  - T2: Cp=1
  - T3: CE_bar=0, Li_bar=0
- LDA:
  - T4: Ei_bar=0, Lm_bar=0
  - T5: CE_bar=0, La_bar=0
  - T6: no-op
- ADD:
  - T4: Ei_bar=0, Lm_bar=0
  - T5: CE_bar=0, Lb_bar=0
  - T6: Eu=1, La_bar=0, Su=0
- SUB: same as ADD, with Su=1 held throughout T4-T6.
- OUT:
  - T4: Ea=1, Lo_bar=0
  - T5-T6: no-op
- HLT:
  - On the negedge that leaves T3 with opcode==OP_HLT, the ring enters T4 and freezes there.
  - halted is set to 1 on that same edge.
  - From then on all controls are inactive. Only CLR_bar clears the halt.
- Undefined opcodes: T4-T6 are no-ops and the ring continues to T1. halted stays 0.
- Opcode sampling: opcode is only decoded in T4-T6 and when leaving T3. It is ignored in T1-T3, so fetch-phase changes on the IR nibble have no effect.
- W bus: at most one W-bus driver (Ep, CE_bar low, Ei_bar low, Ea, Eu) may be active in any T-state. This must hold for all opcodes.
- Illegal ring value (not one-hot, reachable only via upset): the next negedge forces T1.
- Timing: control outputs change only after a negedge CLK or on CLR_bar assertion. No glitches are allowed at posedge.

Test Plan:
- Reset mid-cycle: run to T5 of ADD, pulse CLR_bar low for 7 ns -> t_state=000001 and all controls inactive immediately; after release, Ep=1 and Lm_bar=0 until the next negedge.
- Fetch + LDA: opcode=0000 -> across six negedges t_state walks 000001..100000. Required outputs: T1 Ep=1/Lm_bar=0; T2 Cp=1; T3 CE_bar=0/Li_bar=0; T4 Ei_bar=0/Lm_bar=0; T5 CE_bar=0/La_bar=0; T6 all inactive; then back to T1.
- ADD vs SUB: opcode=0001 -> T5 Lb_bar=0, T6 Eu=1/La_bar=0/Su=0. Repeat with opcode=0010 -> Su=1 in T4, T5 and T6, with T6 Eu=1/La_bar=0.
- OUT and undefined opcode: opcode=1110 -> T4 Ea=1/Lo_bar=0, T5-T6 idle. Then opcode=0101 -> T4-T6 all inactive, ring returns to T1, halted=0.
- HLT: program sequence LDA, ADD, OUT, HLT -> after the HLT T3, t_state=001000 and halted=1. Over 20 further clocks t_state, halted and all controls stay unchanged. Asserting CLR_bar -> T1 with halted=0.
- Bus-contention checker: over 50 random opcodes, assert every cycle that at most one of {Ep, ~CE_bar, ~Ei_bar, Ea, Eu} is high and that t_state is one-hot.
